// File: rtl/osc_freq_meter.sv
// Gated-window frequency meter: counts osc_in rising edges over WINDOW clk
// cycles and flags the result against an inclusive [lo_thr, hi_thr] band.
module osc_freq_meter #(
  parameter int WINDOW = 1000,
  parameter int CNT_W  = 16,
  parameter int SYNC   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             osc_in,
  input  logic             start,
  input  logic [CNT_W-1:0] lo_thr,
  input  logic [CNT_W-1:0] hi_thr,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             in_range
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    DONE
  } state_t;

  localparam logic [23:0] WIN_M1 = 24'(WINDOW - 1);
  localparam logic [2:0]  ARM_M1 = 3'(SYNC);

  state_t           state;
  logic [SYNC-1:0]  sync_q;
  logic             hist_q;
  logic             rise;
  logic [2:0]       arm_cnt;
  logic [23:0]      win_cnt;
  logic [CNT_W-1:0] edge_q;
  logic             ovf_q;
  logic [CNT_W-1:0] edge_nxt;
  logic             ovf_nxt;

  assign rise = sync_q[SYNC-1] & ~hist_q;

  // Saturating edge count including an edge seen in the current cycle.
  always_comb begin
    edge_nxt = edge_q;
    ovf_nxt  = ovf_q;
    if (rise) begin
      if (&edge_q) ovf_nxt = 1'b1;
      else         edge_nxt = edge_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], osc_in};
      hist_q <= sync_q[SYNC-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      arm_cnt  <= '0;
      win_cnt  <= '0;
      edge_q   <= '0;
      ovf_q    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
      in_range <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= ARM;
            busy    <= 1'b1;
            arm_cnt <= ARM_M1;
          end
        end
        ARM: begin
          edge_q  <= '0;
          ovf_q   <= 1'b0;
          win_cnt <= WIN_M1;
          arm_cnt <= arm_cnt - 1'b1;
          if (arm_cnt == 3'd0) state <= MEASURE;
        end
        MEASURE: begin
          edge_q  <= edge_nxt;
          ovf_q   <= ovf_nxt;
          win_cnt <= win_cnt - 1'b1;
          if (win_cnt == 24'd0) begin
            state    <= DONE;
            done     <= 1'b1;
            count    <= edge_nxt;
            overflow <= ovf_nxt;
            in_range <= ~ovf_nxt &&
                        (lo_thr <= edge_nxt) &&
                        (edge_nxt <= hi_thr);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
